// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, requester ids, storeops and word size.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_EXT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_EXT  = 1'b1
  } req_id_t;

  localparam logic [1:0] STORE_WORD = 2'b00;
  localparam logic [1:0] STORE_HALF = 2'b01;
  localparam logic [1:0] STORE_BYTE = 2'b10;

  localparam int unsigned WORDSIZE = 4;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
  function automatic arb_state_t rr_pick(input logic core_want, input logic ext_want,
                                         input req_id_t last);
    arb_state_t nxt;
    nxt = ST_IDLE;
    if (core_want && ext_want) nxt = (last == REQ_CORE) ? ST_EXT : ST_CORE;
    else if (core_want)        nxt = ST_CORE;
    else if (ext_want)         nxt = ST_EXT;
    return nxt;
  endfunction

endpackage

// File: rtl/ram_arb_burst_ctr.sv
// Beat and fairness-window counters for external bursts, plus beat address generation.
module ram_arb_burst_ctr
  import ram_arbiter_pkg::*;
#(
  parameter int LEN_W           = 8,
  parameter int MAX_GRANT_BEATS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beat_en,
  input  logic             burst_end,
  input  logic             preempt,
  input  logic [31:0]      ext_addr,
  input  logic [LEN_W-1:0] ext_len,
  output logic [31:0]      beat_addr,
  output logic             last_beat,
  output logic             window_full
);

  localparam int WIN_W = $clog2(MAX_GRANT_BEATS + 1);
  localparam logic [WIN_W:0] WIN_MAX = (WIN_W + 1)'(MAX_GRANT_BEATS);
  localparam logic [31:0] ADDR_MASK = ~(32'(WORDSIZE) - 32'd1);

  logic [LEN_W-1:0] beat;
  logic [WIN_W-1:0] window;

  // The beat count survives a preemption so the burst resumes where it stopped.
  always_ff @(posedge clk) begin
    if (reset || burst_end) begin
      beat   <= '0;
      window <= '0;
    end else if (beat_en) begin
      beat   <= beat + 1'b1;
      window <= preempt ? '0 : window + 1'b1;
    end
  end

  assign beat_addr   = (ext_addr & ADDR_MASK) + 32'(beat) * 32'(WORDSIZE);
  assign last_beat   = (ext_len == '0) || (beat == ext_len - 1'b1);
  assign window_full = ({1'b0, window} + 1'b1) >= WIN_MAX;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the data RAM between the core and an external burst port.
// Optional perf counters are built when RAM_ARB_PERF_EN is defined.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int LEN_W           = 8,
  parameter int MAX_GRANT_BEATS = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wdata,
  input  logic [1:0]       core_storeops,
  output logic             core_gnt,
  output logic [31:0]      core_rdata,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [LEN_W-1:0] ext_len,
  input  logic [31:0]      ext_wdata,
  output logic             ext_gnt,
  output logic [31:0]      ext_rdata,
  output logic             ext_done,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  output logic             ram_memread,
  output logic             ram_memwrite,
  output logic [1:0]       ram_storeops,
  input  logic [31:0]      ram_rdata,
`ifdef RAM_ARB_PERF_EN
  output logic [31:0]      perf_core_wait,
  output logic [31:0]      perf_ext_beats,
`endif
  output arb_state_t       dbg_state
);

  arb_state_t state;
  arb_state_t pick;
  req_id_t    last_grant;
  logic       ext_active;
  logic [31:0] beat_addr;
  logic       last_beat;
  logic       window_full;
  logic       in_ext;
  logic       beat_en;
  logic       burst_end;
  logic       preempt;

  assign in_ext    = (state == ST_EXT);
  assign beat_en   = in_ext && (ext_len != '0);
  assign burst_end = in_ext && last_beat;
  assign preempt   = beat_en && !last_beat && core_req && window_full;
  assign dbg_state = state;

  ram_arb_burst_ctr #(
    .LEN_W           (LEN_W),
    .MAX_GRANT_BEATS (MAX_GRANT_BEATS)
  ) u_burst_ctr (
    .clk         (CLK),
    .reset       (reset),
    .beat_en     (beat_en),
    .burst_end   (burst_end),
    .preempt     (preempt),
    .ext_addr    (ext_addr),
    .ext_len     (ext_len),
    .beat_addr   (beat_addr),
    .last_beat   (last_beat),
    .window_full (window_full)
  );

  // A finished burst no longer competes; the port must drop ext_req after ext_done.
  always_comb begin
    pick = ST_IDLE;
    case (state)
      ST_IDLE: pick = rr_pick(core_req, ext_req || ext_active, last_grant);
      ST_CORE: pick = rr_pick(core_req, ext_req || ext_active, REQ_CORE);
      ST_EXT:  pick = rr_pick(core_req, 1'b0, REQ_EXT);
      default: pick = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= REQ_EXT;
      ext_active <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= pick;
        ST_CORE: begin
          last_grant <= REQ_CORE;
          state      <= pick;
        end
        ST_EXT: begin
          if (burst_end) begin
            last_grant <= REQ_EXT;
            ext_active <= 1'b0;
            state      <= pick;
          end else begin
            ext_active <= 1'b1;
            if (preempt) state <= ST_CORE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    core_gnt     = 1'b0;
    core_rdata   = '0;
    ext_gnt      = 1'b0;
    ext_rdata    = '0;
    ext_done     = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_memread  = 1'b0;
    ram_memwrite = 1'b0;
    ram_storeops = '0;
    if (!reset) begin
      case (state)
        ST_CORE: begin
          ram_addr     = core_addr;
          ram_wdata    = core_wdata;
          ram_memread  = ~core_we;
          ram_memwrite = core_we;
          ram_storeops = core_storeops;
          core_gnt     = 1'b1;
          core_rdata   = ram_rdata;
        end
        ST_EXT: begin
          if (beat_en) begin
            ram_addr     = beat_addr;
            ram_wdata    = ext_wdata;
            ram_memread  = ~ext_we;
            ram_memwrite = ext_we;
            ram_storeops = STORE_WORD;
            ext_gnt      = 1'b1;
            ext_rdata    = ram_rdata;
          end
          ext_done = last_beat;
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_ARB_PERF_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      perf_core_wait <= '0;
      perf_ext_beats <= '0;
    end else begin
      if (core_req && !core_gnt && perf_core_wait != '1) perf_core_wait <= perf_core_wait + 32'd1;
      if (ext_gnt && perf_ext_beats != '1) perf_ext_beats <= perf_ext_beats + 32'd1;
    end
  end
`endif

endmodule
